// File: rtl/img_xform_pkg.sv
// Shared definitions for the image transform engine: the transform mode codes,
// the controller state encoding and the output-to-source coordinate mapping.
package img_xform_pkg;

    // Geometric transform selected per frame by the command handshake
    typedef enum logic [2:0] {
        MODE_ID     = 3'd0,
        MODE_CCW90  = 3'd1,
        MODE_CW90   = 3'd2,
        MODE_ROT180 = 3'd3,
        MODE_MIRH   = 3'd4,
        MODE_MIRV   = 3'd5,
        MODE_TRANS  = 3'd6,
        MODE_ATRANS = 3'd7
    } mode_t;

    // Controller state: wait for a command, fill the frame store, replay it
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Source coordinate pair; callers keep only the low XW / YW bits, which
    // gives the modulo-2^XW / 2^YW arithmetic for free.
    typedef struct packed {
        logic [31:0] sx;
        logic [31:0] sy;
    } src_xy_t;

    // Modes that exchange the roles of rows and columns (output is H wide)
    function automatic logic mode_swaps(input mode_t mode);
        logic swaps;
        swaps = 1'b0;
        case (mode)
            MODE_CCW90, MODE_CW90, MODE_TRANS, MODE_ATRANS: swaps = 1'b1;
            default:                                        swaps = 1'b0;
        endcase
        return swaps;
    endfunction

    // Map an output raster position (ox,oy) to the stored pixel (sx,sy).
    // wm1 / hm1 are the input frame width-1 and height-1.
    function automatic src_xy_t xform_src(input mode_t mode,
                                          input logic [31:0] ox,
                                          input logic [31:0] oy,
                                          input logic [31:0] wm1,
                                          input logic [31:0] hm1);
        src_xy_t s;
        s.sx = ox;
        s.sy = oy;
        case (mode)
            MODE_ID:     begin s.sx = ox;       s.sy = oy;       end
            MODE_CCW90:  begin s.sx = wm1 - oy; s.sy = ox;       end
            MODE_CW90:   begin s.sx = oy;       s.sy = hm1 - ox; end
            MODE_ROT180: begin s.sx = wm1 - ox; s.sy = hm1 - oy; end
            MODE_MIRH:   begin s.sx = wm1 - ox; s.sy = oy;       end
            MODE_MIRV:   begin s.sx = ox;       s.sy = hm1 - oy; end
            MODE_TRANS:  begin s.sx = oy;       s.sy = ox;       end
            MODE_ATRANS: begin s.sx = wm1 - oy; s.sy = hm1 - ox; end
            default:     begin s.sx = ox;       s.sy = oy;       end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/img_sram.sv
// Single-port synchronous frame store with a registered read port.
// A write in the same cycle as a read request wins; the read data register
// then keeps its previous value.
module img_sram #(
    parameter int DW    = 24,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_reg;

    // One access per cycle: write has priority, otherwise an optional read
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/img_xform_engine.sv
// Frame-buffering geometric transform engine. A command starts a frame; the
// input raster is stored in a single-port frame store, then replayed in one of
// eight orientations through a 2-entry skid buffer with full backpressure.
// Optional build macro IMG_XFORM_SOF_EOL_EN adds the out_sof / out_eol
// sideband outputs, carried through the skid buffer alongside the pixel.
module img_xform_engine
    import img_xform_pkg::*;
#(
    parameter int PIX_W = 24,
    parameter int IMG_W = 1024,
    parameter int IMG_H = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_mode,
    output logic             cmd_ready,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
`ifdef IMG_XFORM_SOF_EOL_EN
    output logic             out_sof,
    output logic             out_eol,
`endif
    output logic             busy,
    output logic             done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int IW = (XW > YW) ? XW : YW;
    localparam int AW = XW + YW;
`ifdef IMG_XFORM_SOF_EOL_EN
    localparam int SIDE_W = 3;   // {last, sof, eol}
`else
    localparam int SIDE_W = 1;   // {last}
`endif
    localparam int SB_W = PIX_W + SIDE_W;

    state_t             state_reg;
    mode_t              mode_reg;
    logic [XW-1:0]      x_reg;
    logic [YW-1:0]      y_reg;
    logic [IW-1:0]      ox_reg;
    logic [IW-1:0]      oy_reg;
    logic               issued_all_reg;
    logic               done_reg;
    logic               rd_pend_reg;
    logic [SIDE_W-1:0]  rd_side_reg;
    logic [SB_W-1:0]    sb0_reg;
    logic [SB_W-1:0]    sb1_reg;
    logic [1:0]         sb_cnt_reg;

    logic               load_beat;
    logic               load_end;
    logic [IW-1:0]      ow_m1;
    logic [IW-1:0]      oh_m1;
    logic               pop;
    logic [1:0]         occ;
    logic               issue;
    logic               rd_final;
    src_xy_t            src;
    logic [XW-1:0]      sx;
    logic [YW-1:0]      sy;
    logic [AW-1:0]      sram_addr;
    logic [PIX_W-1:0]   sram_rdata;
    logic [SIDE_W-1:0]  side_issue;
    logic [SB_W-1:0]    push_data;
    logic               unused_src_bits;

    assign load_beat = (state_reg == ST_LOAD) && in_valid;
    assign load_end  = load_beat && (x_reg == XW'(IMG_W - 1)) && (y_reg == YW'(IMG_H - 1));

    assign ow_m1 = mode_swaps(mode_reg) ? IW'(IMG_H - 1) : IW'(IMG_W - 1);
    assign oh_m1 = mode_swaps(mode_reg) ? IW'(IMG_W - 1) : IW'(IMG_H - 1);

    // A read may be issued when the skid buffer plus the read in flight leave
    // a slot, or when the head is being accepted this cycle.
    assign pop      = (sb_cnt_reg != 2'd0) && out_ready;
    assign occ      = sb_cnt_reg + {1'b0, rd_pend_reg};
    assign issue    = (state_reg == ST_DRAIN) && !issued_all_reg && ((occ < 2'd2) || pop);
    assign rd_final = (ox_reg == ow_m1) && (oy_reg == oh_m1);

    assign src = xform_src(mode_reg, 32'(ox_reg), 32'(oy_reg),
                           32'(IMG_W - 1), 32'(IMG_H - 1));
    assign sx  = src.sx[XW-1:0];
    assign sy  = src.sy[YW-1:0];
    assign unused_src_bits = ^{src.sx[31:XW], src.sy[31:YW]};

    assign sram_addr = (state_reg == ST_LOAD) ? {y_reg, x_reg} : {sy, sx};

`ifdef IMG_XFORM_SOF_EOL_EN
    assign side_issue = {rd_final, (ox_reg == '0) && (oy_reg == '0), ox_reg == ow_m1};
`else
    assign side_issue = rd_final;
`endif
    assign push_data = {rd_side_reg, sram_rdata};

    img_sram #(
        .DW    (PIX_W),
        .DEPTH (IMG_W * IMG_H),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .we    (load_beat),
        .re    (issue),
        .addr  (sram_addr),
        .wdata (in_data),
        .rdata (sram_rdata)
    );

    // Controller: command accept, load raster counters, drain raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            mode_reg       <= MODE_ID;
            x_reg          <= '0;
            y_reg          <= '0;
            ox_reg         <= '0;
            oy_reg         <= '0;
            issued_all_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        mode_reg  <= mode_t'(cmd_mode);
                        x_reg     <= '0;
                        y_reg     <= '0;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_beat) begin
                        x_reg <= x_reg + 1'b1;
                        if (x_reg == XW'(IMG_W - 1)) begin
                            y_reg <= y_reg + 1'b1;
                        end
                    end
                    if (load_end) begin
                        x_reg          <= '0;
                        y_reg          <= '0;
                        ox_reg         <= '0;
                        oy_reg         <= '0;
                        issued_all_reg <= 1'b0;
                        state_reg      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (issue) begin
                        if (ox_reg == ow_m1) begin
                            ox_reg <= '0;
                            oy_reg <= oy_reg + 1'b1;
                        end else begin
                            ox_reg <= ox_reg + 1'b1;
                        end
                        if (rd_final) begin
                            issued_all_reg <= 1'b1;
                        end
                    end
                    if (pop && sb0_reg[SB_W-1]) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Read-return tracking and the 2-entry output skid FIFO (head in sb0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_reg <= 1'b0;
            rd_side_reg <= '0;
            sb0_reg     <= '0;
            sb1_reg     <= '0;
            sb_cnt_reg  <= 2'd0;
        end else begin
            rd_pend_reg <= issue;
            if (issue) begin
                rd_side_reg <= side_issue;
            end
            case ({rd_pend_reg, pop})
                2'b10: begin
                    if (sb_cnt_reg == 2'd0) begin
                        sb0_reg <= push_data;
                    end else begin
                        sb1_reg <= push_data;
                    end
                    sb_cnt_reg <= sb_cnt_reg + 2'd1;
                end
                2'b01: begin
                    sb0_reg    <= sb1_reg;
                    sb_cnt_reg <= sb_cnt_reg - 2'd1;
                end
                2'b11: begin
                    if (sb_cnt_reg == 2'd1) begin
                        sb0_reg <= push_data;
                    end else begin
                        sb0_reg <= sb1_reg;
                        sb1_reg <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign in_ready  = (state_reg == ST_LOAD);
    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;
    assign out_valid = (sb_cnt_reg != 2'd0);
    assign out_data  = sb0_reg[PIX_W-1:0];
    assign out_last  = sb0_reg[SB_W-1];
`ifdef IMG_XFORM_SOF_EOL_EN
    assign out_sof   = sb0_reg[PIX_W+1];
    assign out_eol   = sb0_reg[PIX_W];
`endif

endmodule

// File: tb/tb_img_xform_engine.sv
// Scoreboard bench for img_xform_engine on a 4x2 frame of 8-bit pixels whose
// value is y*4+x. Expected output sequences are hand-written per mode.
module tb_img_xform_engine;

    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [2:0]       cmd_mode = 3'd0;
    logic             cmd_ready;
    logic             in_valid = 1'b0;
    logic [PIX_W-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [PIX_W-1:0] out_data;
    logic             out_ready = 1'b1;
    logic             out_last;
`ifdef IMG_XFORM_SOF_EOL_EN
    logic             out_sof;
    logic             out_eol;
`endif
    logic             busy;
    logic             done;

    img_xform_engine #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_mode  (cmd_mode),
        .cmd_ready (cmd_ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
`ifdef IMG_XFORM_SOF_EOL_EN
        .out_sof   (out_sof),
        .out_eol   (out_eol),
`endif
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       sof;
        logic       eol;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] exp_tab [8];
    int          checks = 0;
    int          failures = 0;
    int          beat_idx = 0;
    bit          rand_ready = 1'b0;
    bit          hold_valid = 1'b0;
    logic [8:0]  hold_word = '0;
    bit          expect_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, exp);
        end
    endtask

    // Downstream ready: always 1, or stalled about 30% of cycles
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted beat, checks stall hold and done
    always @(negedge clk) begin
        if (rst) begin
            hold_valid  = 1'b0;
            expect_done = 1'b0;
        end else begin
            if (expect_done) begin
                check("done_pulse", 32'(done), 32'd1);
                expect_done = 1'b0;
            end else if (done) begin
                check("done_spurious", 32'(done), 32'd0);
            end
            if (hold_valid) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({out_last, out_data}), 32'(hold_word));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_beat got=%0d required=no_beat", out_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("beat%0d_data", beat_idx), 32'(out_data), 32'(e.data));
                    check($sformatf("beat%0d_last", beat_idx), 32'(out_last), 32'(e.last));
`ifdef IMG_XFORM_SOF_EOL_EN
                    check($sformatf("beat%0d_sof", beat_idx), 32'(out_sof), 32'(e.sof));
                    check($sformatf("beat%0d_eol", beat_idx), 32'(out_eol), 32'(e.eol));
`endif
                    beat_idx++;
                end
                if (out_last) expect_done = 1'b1;
            end
            hold_valid = out_valid && !out_ready;
            hold_word  = {out_last, out_data};
        end
    end

    // One complete frame: command, 8 load beats, drain with latency/throughput checks
    task automatic run_frame(input int m, input bit rnd, input bit noise);
        logic [63:0] seq;
        int ow;
        int cyc;
        seq = exp_tab[m];
        ow  = (m == 1 || m == 2 || m == 6 || m == 7) ? IMG_H : IMG_W;
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.data = seq[63 - 8*i -: 8];
            e.last = (i == 7);
            e.sof  = (i == 0);
            e.eol  = ((i % ow) == ow - 1);
            sb_q.push_back(e);
        end
        rand_ready = rnd;
        cmd_valid  = 1'b1;
        cmd_mode   = 3'(m);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int bound;
            in_valid = 1'b1;
            in_data  = 8'(i);
            if (noise && i >= 2) begin
                cmd_valid = 1'b1;
                cmd_mode  = 3'd3;
                check("load_cmd_ready", 32'(cmd_ready), 32'd0);
                check("load_busy", 32'(busy), 32'd1);
            end
            bound = 0;
            while (!in_ready && bound < 50) begin
                @(posedge clk);
                #1;
                bound++;
            end
            if (bound == 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!rnd) begin
            check("drain_lat0_valid", 32'(out_valid), 32'd0);
            check("drain_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check("drain_lat1_valid", 32'(out_valid), 32'd0);
            if (noise) begin
                check("drain_cmd_ready", 32'(cmd_ready), 32'd0);
                check("drain_busy", 32'(busy), 32'd1);
            end
            @(posedge clk);
            #1;
            check("drain_lat2_valid", 32'(out_valid), 32'd1);
        end
        cmd_valid = 1'b0;
        cyc = 0;
        while (!done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 400) check("frame_timeout", 32'(done), 32'd1);
        else if (!rnd) check($sformatf("mode%0d_drain_cycles", m), 32'(cyc), 32'd8);
        @(posedge clk);
        #1;
        check($sformatf("mode%0d_queue_empty", m), 32'(sb_q.size()), 32'd0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        rand_ready = 1'b0;
        $display("frame mode=%0d rnd=%0d noise=%0d complete checks=%0d", m, rnd, noise, checks);
    endtask

    initial begin
        exp_tab[0] = 64'h00_01_02_03_04_05_06_07;
        exp_tab[1] = 64'h03_07_02_06_01_05_00_04;
        exp_tab[2] = 64'h04_00_05_01_06_02_07_03;
        exp_tab[3] = 64'h07_06_05_04_03_02_01_00;
        exp_tab[4] = 64'h03_02_01_00_07_06_05_04;
        exp_tab[5] = 64'h04_05_06_07_00_01_02_03;
        exp_tab[6] = 64'h00_04_01_05_02_06_03_07;
        exp_tab[7] = 64'h07_03_06_02_05_01_04_00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_frame(0, 1'b0, 1'b0);
        run_frame(3, 1'b0, 1'b0);
        run_frame(4, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0);
        run_frame(2, 1'b0, 1'b0);
        run_frame(6, 1'b0, 1'b0);
        run_frame(5, 1'b0, 1'b0);
        run_frame(7, 1'b0, 1'b0);
        run_frame(0, 1'b1, 1'b0);
        run_frame(0, 1'b1, 1'b0);
        run_frame(0, 1'b0, 1'b1);

        // Abort a frame after 5 load beats with reset
        cmd_valid = 1'b1;
        cmd_mode  = 3'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("mid-frame reset applied");

        run_frame(1, 1'b0, 1'b0);
        run_frame(3, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/img_xform_engine.md
Name: img_xform_engine

Overview:
Parametrised successor to the fixed 1024x1024 store/rotate adapter. It buffers one full frame from a valid/ready pixel stream into an on-chip single-port SRAM, then replays it under one of 8 geometric transforms on a valid/ready output stream. The output side applies full backpressure. A command handshake starts each frame. The block sits between the pixel source and the downstream display/DMA stage.

Parameters:
PIX_W, 24, pixel width in bits
IMG_W, 1024, input frame width in pixels; power of two, >=2
IMG_H, 1024, input frame height in pixels; power of two, >=2
XW, $clog2(IMG_W), column index width (derived, not overridden)
YW, $clog2(IMG_H), row index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  start request
cmd_mode  in  3  transform code, sampled on cmd accept
cmd_ready  out  1  high only in IDLE
in_valid  in  1  input pixel valid
in_data  in  PIX_W  input pixel, row-major raster
in_ready  out  1  high only in LOAD
out_valid  out  1  output pixel valid
out_data  out  PIX_W  transformed pixel, row-major raster of output frame
out_ready  in  1  downstream accept
out_last  out  1  qualifies the final output pixel of the frame
busy  out  1  high in LOAD or DRAIN
done  out  1  single-cycle pulse after the last output beat is accepted

Behaviour:
- Reset (async, any state, mid-frame included): FSM to IDLE. cmd_ready=1; in_ready, out_valid, out_last, busy and done =0. Counters and the skid buffer are cleared. SRAM contents are undefined.
- FSM IDLE -> LOAD on cmd_valid&cmd_ready; mode latched. cmd_valid is ignored outside IDLE.
- LOAD: each in_valid&in_ready beat writes SRAM addr {y,x}. x wraps at IMG_W-1 and increments y. On the beat at (IMG_W-1, IMG_H-1): -> DRAIN, counters cleared, in_ready drops the next cycle.
- DRAIN: output raster (ox,oy) over OW x OH. OW=IMG_H, OH=IMG_W for modes 1,2,6,7; otherwise OW=IMG_W, OH=IMG_H. The read address is {sy,sx}, with the mapping below:
  0 identity: (ox, oy)
  1 rot CCW90: (W-1-oy, ox)
  2 rot CW90: (oy, H-1-ox)
  3 rot180: (W-1-ox, H-1-oy)
  4 mirror horizontal: (W-1-ox, oy)
  5 mirror vertical: (ox, H-1-oy)
  6 transpose: (oy, ox)
  7 anti-transpose: (W-1-oy, H-1-ox)
  All arithmetic is modulo 2^XW / 2^YW. Index widths are max(XW,YW), truncated per field.
- SRAM read latency is 1 cycle. A 2-entry skid buffer sits on the output. A read is issued only when a buffer slot is free or will be freed this cycle.
- First out_valid comes 2 cycles after entering DRAIN if out_ready is held high. Sustained throughput is 1 pixel/cycle with out_ready=1. No beat is lost or duplicated under any out_ready pattern.
- out_data and out_last hold stable while out_valid&!out_ready.
- out_last is high with the final pixel only. When that pixel is accepted: -> IDLE, and done=1 for 1 cycle on the following cycle.
- LOAD and DRAIN never overlap, because the SRAM is single-port.

Optional Feature:
IMG_XFORM_SOF_EOL_EN: adds an output port out_sof (1 bit, high with the output pixel (0,0)) and an output port out_eol (high when ox==OW-1). Both travel through the skid buffer with the data. Without the macro these ports and their buffer bits do not exist, and out_last is the only sideband.

Decomposition:
- Package img_xform_pkg holds the mode enum (MODE_ID..MODE_ATRANS, 3-bit), the FSM state encoding and the function computing (sx,sy) from (mode,ox,oy).
- One sub-module, img_sram: parametrised single-port synchronous RAM (DEPTH=IMG_W*IMG_H, width PIX_W), registered read, write-enable dominant.

Test Plan:
- IMG_W=4, IMG_H=2, PIX_W=8, input pixel = y*4+x, out_ready=1. Mode 0 -> 0..7; mode 3 -> 7,6,5,4,3,2,1,0; mode 4 -> 3,2,1,0,7,6,5,4.
- Same frame, mode 1 -> 3,7,2,6,1,5,0,4; mode 2 -> 4,0,5,1,6,2,7,3; mode 6 -> 0,4,1,5,2,6,3,7. out_last is set on the 8th beat; done pulses one cycle after.
- Mode 0 with out_ready toggling randomly at 30% -> exact sequence 0..7, data held while stalled, no drop or duplicate.
- cmd_valid pulsed during LOAD and DRAIN -> ignored; cmd_ready=0 and busy=1 throughout.
- rst asserted after 5 input beats -> next cycle cmd_ready=1, out_valid=0. A fresh command then runs a full frame correctly.
- With IMG_XFORM_SOF_EOL_EN, mode 1 -> out_sof on beat 0, out_eol on beats 1,3,5,7.
